// File: rtl/stream_switch_pkg.sv
// stream_switch_pkg: header field layout, parser states and tile count shared by the switch
package stream_switch_pkg;
    localparam int NUM_TILES = 4;
    localparam int DEST_LSB  = 0;
    localparam int LEN_LSB   = 2;
    localparam int BCAST_BIT = 6;
    localparam int RSVD_BIT  = 7;
    typedef enum logic {HDR, PAYLOAD} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: 8-bit synchronous FIFO with wrap-bit pointers to tell full from empty
module sync_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= (push && !full) ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= (pop && !empty) ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/stream_switch.sv
// stream_switch: buffers a framed host byte stream and forwards payload to one or all tile ports
module stream_switch
    import stream_switch_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   hold,
    output logic [8*NUM_TILES-1:0] tile_data,
    output logic [NUM_TILES-1:0]   tile_strobe,
    output logic                   busy,
    output logic                   err
);
    state_t     state;
    logic [3:0] count;
    logic [1:0] dest;
    logic       bcast;
    logic [7:0] fifo_dout;
    logic       full, empty, pop;
    assign in_ready = !full;
    assign pop      = !empty && !hold;
    assign busy     = (state == PAYLOAD) || !empty;
    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR;
            count       <= '0;
            dest        <= '0;
            bcast       <= 1'b0;
            tile_data   <= {NUM_TILES{IDLE_BYTE}};
            tile_strobe <= '0;
            err         <= 1'b0;
        end else begin
            tile_strobe <= '0;
            if (pop && state == HDR) begin
                if (fifo_dout[RSVD_BIT]) begin
                    err <= 1'b1;
                end else begin
                    dest  <= fifo_dout[DEST_LSB +: 2];
                    count <= fifo_dout[LEN_LSB +: 4];
                    bcast <= fifo_dout[BCAST_BIT];
                    state <= PAYLOAD;
                end
            end else if (pop) begin
                for (int t = 0; t < NUM_TILES; t++) begin
                    if (bcast || dest == 2'(t)) begin
                        tile_data[8*t +: 8] <= fifo_dout;
                        tile_strobe[t]      <= 1'b1;
                    end
                end
                state <= (count == 4'd0) ? HDR : PAYLOAD;
                count <= count - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_stream_switch.sv
// tb_stream_switch: directed stimulus with a scoreboard of hand-computed tile deliveries
module tb_stream_switch;
    import stream_switch_pkg::*;
    typedef struct {
        logic [3:0] mask;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    logic        clk = 0;
    logic        rst_n = 1;
    logic        in_valid = 0;
    logic        hold = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, busy, err;
    logic [31:0] tile_data;
    logic [3:0]  tile_strobe;
    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  model[4];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          k, pc;
    logic [7:0]  d;

    stream_switch #(.FIFO_DEPTH(4), .IDLE_BYTE(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .hold        (hold),
        .tile_data   (tile_data),
        .tile_strobe (tile_strobe),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b, output int pcyc);
        int n = 0;
        @(negedge clk);
        in_valid = 1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL push_timeout: in_ready got 0 expected 1 for byte %0h", b);
            in_valid = 0;
            pcyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        pcyc = cyc;
        in_valid = 0;
    endtask

    task automatic expect_d(input logic [3:0] mask, input logic [7:0] data, input int c);
        sb.push_back('{mask, data, c});
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 500);
        if (busy || sb.size() != 0) begin
            n_chk++;
            $display("FAIL idle_timeout: busy %0d pending %0d expected 0 0", busy, sb.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] packed_model();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && tile_strobe != 0) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_strobe: got %0h expected 0", tile_strobe);
            end else begin
                e = sb.pop_front();
                chk("strobe", 32'(tile_strobe), 32'(e.mask));
                if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
                for (int t = 0; t < 4; t++) if (e.mask[t]) model[t] = e.data;
                chk("tile_data", tile_data, packed_model());
            end
        end
    end

    initial begin
        for (int t = 0; t < 4; t++) model[t] = 8'h00;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_tile_data", tile_data, 32'h0);
        chk("rst_strobe", 32'(tile_strobe), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        push(8'h05, k);
        push(8'h03, pc);
        expect_d(4'b0010, 8'h03, k + 2);
        push(8'h82, pc);
        expect_d(4'b0010, 8'h82, k + 3);
        wait_idle();
        chk("unicast_hold", tile_data, 32'h0000_8200);

        push(8'h40, k);
        push(8'h47, pc);
        expect_d(4'b1111, 8'h47, k + 2);
        wait_idle();
        chk("bcast_data", tile_data, 32'h4747_4747);
        chk("bcast_done_busy", 32'(busy), 32'h0);

        push(8'h80, k);
        push(8'h02, pc);
        push(8'h91, pc);
        expect_d(4'b0100, 8'h91, k + 3);
        wait_idle();
        chk("malformed_err", 32'(err), 32'h1);
        chk("malformed_data", tile_data, 32'h4791_4747);

        for (int r = 0; r < 3; r++) begin
            hold = 1;
            push(8'h0F, pc);
            for (int i = 0; i < 3; i++) begin
                d = 8'(8'hA0 + r * 16 + i);
                push(d, pc);
                expect_d(4'b1000, d, -1);
            end
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'h0);
            chk("full_busy", 32'(busy), 32'h1);
            d = 8'(8'hA3 + r * 16);
            fork
                push(d, pc);
                begin
                    repeat (3) @(negedge clk);
                    chk("held_in_ready", 32'(in_ready), 32'h0);
                    chk("held_strobe", 32'(tile_strobe), 32'h0);
                    hold = 0;
                end
            join
            expect_d(4'b1000, d, -1);
            wait_idle();
            chk("wrap_data", 32'(tile_data[31:24]), 32'(8'hA3 + r * 16));
        end
        chk("err_sticky", 32'(err), 32'h1);

        push(8'h3C, pc);
        push(8'h11, pc);
        expect_d(4'b0001, 8'h11, -1);
        push(8'h22, pc);
        expect_d(4'b0001, 8'h22, -1);
        push(8'h33, pc);
        expect_d(4'b0001, 8'h33, -1);
        repeat (3) @(negedge clk);
        chk("midpkt_busy", 32'(busy), 32'h1);
        chk("midpkt_tile0", 32'(tile_data[7:0]), 32'h33);
        #2 rst_n = 0;
        #1;
        for (int t = 0; t < 4; t++) model[t] = 8'h00;
        chk("rst2_tile_data", tile_data, 32'h0);
        chk("rst2_busy", 32'(busy), 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1;
        push(8'h01, k);
        push(8'hAA, pc);
        expect_d(4'b0010, 8'hAA, k + 2);
        wait_idle();
        chk("post_rst_data", tile_data, 32'h0000_AA00);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
